// File: rtl/acc_seq.sv
// acc_seq: frame accumulator. Sums an unsigned operand stream into an
// aw = width+guard bit accumulator, counts terms (saturating), flags carry-out
// and presents the frame result on a valid/ready output until consumed.
// Optional feature macro: ACC_SAT_EN (clamp the accumulator on overflow
// instead of wrapping).
module acc_seq #(
  parameter int unsigned width     = 16,
  parameter int unsigned guard     = 4,
  parameter int unsigned cnt_width = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [width-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [width+guard-1:0]     out_sum,
  output logic [cnt_width-1:0]       out_count,
  output logic                       out_ovf
);

  localparam int unsigned aw = width + guard;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  logic [aw-1:0]        r_acc;
  logic [cnt_width-1:0] r_count;
  logic                 r_ovf;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [aw-1:0]        r_out_sum;
  logic [cnt_width-1:0] r_out_count;
  logic                 r_out_ovf;

  logic                 w_accept;
  logic [aw:0]          w_sum;
  logic                 w_carry;
  logic [aw-1:0]        w_acc_next;
  logic [aw-1:0]        w_first;
  logic [cnt_width-1:0] w_cnt_next;
  logic                 w_ovf_next;

  // Accept only when ready; ready is a registered copy of "not in HOLD".
  assign w_accept = in_valid & r_in_ready;

  // One extra bit so the carry out of the accumulator is visible.
  assign w_sum   = {1'b0, r_acc} + (aw+1)'(in_data);
  assign w_carry = w_sum[aw];
  assign w_first = aw'(in_data);

`ifdef ACC_SAT_EN
  // Once the frame has overflowed, the accumulator stays pinned at full scale.
  assign w_acc_next = (r_ovf | w_carry) ? {aw{1'b1}} : w_sum[aw-1:0];
`else
  // Wrap modulo 2^aw; the sticky flag still records the overflow.
  assign w_acc_next = w_sum[aw-1:0];
`endif

  assign w_ovf_next = r_ovf | w_carry;

  // Term counter sticks at its maximum instead of wrapping.
  assign w_cnt_next = (r_count == {cnt_width{1'b1}}) ? r_count
                                                     : r_count + cnt_width'(1);

  // Frame FSM with accumulator, counter and registered output ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_first;
            r_count <= cnt_width'(1);
            r_ovf   <= 1'b0;
            if (in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_first;
              r_out_count <= cnt_width'(1);
              r_out_ovf   <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            if (in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_sum   <= w_acc_next;
              r_out_count <= w_cnt_next;
              r_out_ovf   <= w_ovf_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_sum   <= '0;
          r_out_count <= '0;
          r_out_ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq: default instance plus a cnt_width=2 instance
// sharing the same input stream.
module tb_acc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic        c2_in_ready;
  logic        c2_out_valid;
  logic [19:0] c2_out_sum;
  logic [1:0]  c2_out_count;
  logic        c2_out_ovf;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acc_seq u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  acc_seq #(.width(16), .guard(4), .cnt_width(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(c2_out_valid),
    .out_ready(out_ready), .out_sum(c2_out_sum), .out_count(c2_out_count),
    .out_ovf(c2_out_ovf)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one operand and hold it until accepted (bounded wait).
  task automatic drive(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL drive_timeout: in_ready=%0b, required 1", in_ready);
    end
    step(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %0b want 1", in_ready); end
    vectors++;
    if ({out_sum, out_count, out_ovf} !== 29'd0) begin miscompares++; $display("FAIL rst_outs: sum=%0h cnt=%0d ovf=%0b want 0", out_sum, out_count, out_ovf); end
    rst = 1'b0;
    step(1);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(16'd3, 1'b0);
    drive(16'd5, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    drive(16'd7, 1'b1);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    vectors++;
    if (out_sum !== 20'd15 || out_count !== 8'd3 || out_ovf !== 1'b0) begin
      miscompares++; $display("FAIL basic_result: sum=%0d cnt=%0d ovf=%0b want 15/3/0", out_sum, out_count, out_ovf);
    end
    step(1);
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== 20'd0 || out_count !== 8'd0) begin
      miscompares++; $display("FAIL basic_drop: valid=%0b sum=%0d cnt=%0d want 0/0/0", out_valid, out_sum, out_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    drive(16'hFFFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL single_hold%0d: valid=%0b ready=%0b want 1/0", k, out_valid, in_ready);
      end
      vectors++;
      if (out_sum !== 20'h0FFFF || out_count !== 8'd1 || out_ovf !== 1'b0) begin
        miscompares++; $display("FAIL single_result%0d: sum=%0h cnt=%0d ovf=%0b want 0ffff/1/0", k, out_sum, out_count, out_ovf);
      end
      step(1);
    end
    release_hold();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL single_release: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] exp_sum;
`ifdef ACC_SAT_EN
    exp_sum = 20'hFFFFF;
`else
    exp_sum = 20'hFFFE0;
`endif
    out_ready = 1'b0;
    for (int k = 0; k < 31; k++) drive(16'hFFFF, 1'b0);
    drive(16'hFFFF, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_ovf !== 1'b1) begin
      miscompares++; $display("FAIL ovf_flag: valid=%0b ovf=%0b want 1/1", out_valid, out_ovf);
    end
    vectors++;
    if (out_sum !== exp_sum) begin miscompares++; $display("FAIL ovf_sum: got %0h want %0h", out_sum, exp_sum); end
    vectors++;
    if (out_count !== 8'd32) begin miscompares++; $display("FAIL ovf_count: got %0d want 32", out_count); end
    vectors++;
    if (c2_out_count !== 2'd3) begin miscompares++; $display("FAIL ovf_c2_count: got %0d want 3", c2_out_count); end
    release_hold();
    step(1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(16'd1, 1'b0);
    step(3);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_gap: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
    drive(16'd2, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 20'd3 || out_count !== 8'd2) begin
      miscompares++; $display("FAIL b2b_first: valid=%0b sum=%0d cnt=%0d want 1/3/2", out_valid, out_sum, out_count);
    end
    in_valid = 1'b1;
    in_data  = 16'd10;
    in_last  = 1'b1;
    step(2);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 20'd3 || out_count !== 8'd2) begin
      miscompares++; $display("FAIL b2b_blocked: valid=%0b sum=%0d cnt=%0d want 1/3/2", out_valid, out_sum, out_count);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_handshake: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
    end
    step(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 20'd10 || out_count !== 8'd1) begin
      miscompares++; $display("FAIL b2b_second: valid=%0b sum=%0d cnt=%0d want 1/10/1", out_valid, out_sum, out_count);
    end
    release_hold();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(16'd1, 1'b0);
    drive(16'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 8'd0 || out_sum !== 20'd0) begin
      miscompares++; $display("FAIL rstmid_async: valid=%0b sum=%0d cnt=%0d want 0/0/0", out_valid, out_sum, out_count);
    end
    step(1);
    rst = 1'b0;
    step(1);
    drive(16'd4, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== 20'd4 || out_count !== 8'd1) begin
      miscompares++; $display("FAIL rstmid_result: valid=%0b sum=%0d cnt=%0d want 1/4/1", out_valid, out_sum, out_count);
    end
    release_hold();
    step(2);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale: valid=%0b want 0", out_valid); end
    drive(16'd9, 1'b1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== 20'd0) begin
      miscompares++; $display("FAIL rsthold: valid=%0b sum=%0d want 0/0", out_valid, out_sum);
    end
    step(1);
    rst = 1'b0;
    step(1);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rsthold_after: ready=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_cnt_sat();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive(16'd1, 1'b0);
    drive(16'd1, 1'b1);
    vectors++;
    if (c2_out_valid !== 1'b1 || c2_out_count !== 2'd3 || c2_out_sum !== 20'd5) begin
      miscompares++; $display("FAIL cntsat_c2: valid=%0b sum=%0d cnt=%0d want 1/5/3", c2_out_valid, c2_out_sum, c2_out_count);
    end
    vectors++;
    if (out_count !== 8'd5 || out_sum !== 20'd5) begin
      miscompares++; $display("FAIL cntsat_main: sum=%0d cnt=%0d want 5/5", out_sum, out_count);
    end
    release_hold();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_cnt_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
